posit_encode_raw_es3: RTL and testbench
=======================================

POSIT_ENCODE_RAW_ES3 -- requirements
Module: posit_encode_raw_es3

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; clk and rst are the only timing inputs.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  qualifies in_sum and in_truncated on the sampling edge; X is treated as 0.
REQ-005 in_sum  input  POSIT_SERIALIZED_WIDTH_SUM_ES3 (41)  raw sum.
- Fields: sgn [40], scale [39:31] (9-bit two's complement), fraction [30:2] (29 bits, hidden bit excluded), inf [1], zero [0].
REQ-006 in_truncated  input  1  upstream discarded nonzero bits; joins the rounding sticky.
REQ-007 result  output  32  posit<32,3> bit pattern.
REQ-008 done  output  1  one-cycle pulse; result and truncated are valid while it is high.
REQ-009 truncated  output  1  encoding was inexact (any discarded bit nonzero).

Function
REQ-010 SHALL be fully pipelined: accept one start per cycle with no stall or backpressure.
REQ-011 Latency: start sampled at edge N SHALL give done=1 after edge N+3; done SHALL be 0 otherwise.
REQ-012 Stage 1 SHALL register the inputs and derive the following from the scale:
- regime k = scale >>> 3 (arithmetic shift), exponent e = scale[2:0].
- regime run length: k+1 ones then a zero for k>=0; -k zeros then a one for k<0.
REQ-013 Stage 2 SHALL form the 62-bit vector {regime, e, fraction} and right-align it into 31 magnitude bits.
- Keep guard = first discarded bit.
- Keep sticky = OR(remaining discarded bits) | in_truncated.
REQ-014 Stage 3 SHALL round the magnitude to nearest, ties to even: increment iff guard & (lsb | sticky).
REQ-015 Rounding SHALL never produce 0 or 0x80000000 from a nonzero finite input.
- Magnitude is clamped to [0x00000001, 0x7FFFFFFF].
REQ-016 A scale above +240 SHALL saturate to magnitude 0x7FFFFFFF; a scale below -240 SHALL saturate to magnitude 0x00000001.
- In both cases truncated=1.
REQ-017 For sgn=1, result SHALL be the two's complement of the 32-bit {0, magnitude}.
REQ-018 Special values:
- inf=1 (priority over zero) SHALL give result=0x80000000, truncated=0.
- zero=1 SHALL give result=0x00000000, truncated=0.
REQ-019 truncated SHALL equal (guard | sticky) for finite nonzero inputs.
REQ-020 Back-to-back starts SHALL produce back-to-back done pulses in input order, with no cross-contamination.
REQ-021 result and truncated SHALL hold their last values while done=0.

Reset
REQ-022 While rst=1, outputs SHALL be done=0, result=0x00000000, truncated=0, and all stage-valid flags SHALL be 0.
- Takes effect asynchronously.
REQ-023 Reset mid-operation SHALL discard all in-flight samples; no done pulse SHALL appear for them after release.
REQ-024 The first start sampled after rst deasserts SHALL complete with the normal 3-cycle latency.

Structure
REQ-025 Package posit_defines_es3 SHALL hold the following; the module SHALL import it and add no local duplicates:
- POSIT_SERIALIZED_WIDTH_SUM_ES3, ABITS.
- value_sum typedef.
- POSIT_ES3_MAXPOS=0x7FFFFFFF, POSIT_ES3_MINPOS=0x00000001, POSIT_ES3_NAR=0x80000000, POSIT_ES3_MAX_SCALE=240.
REQ-026 The Stage-2 alignment SHALL use the existing shift_right sub-module (N=62, S=5); no other sub-module is required.

Verification
REQ-027 scale 0, fraction 0, sgn 0 -> result 0x40000000, truncated 0, done exactly 3 cycles after start.
REQ-028 Encoding vectors:
- scale 8 -> 0x60000000.
- scale 1, fraction 0x10000000 -> 0x46000000.
- sgn 1, scale 0 -> 0xC0000000.
REQ-029 Rounding at scale 0:
- fraction 0x4 -> 0x40000000, truncated 1.
- fraction 0xC -> 0x40000002, truncated 1.
- fraction 0, in_truncated 1 -> 0x40000000, truncated 1.
REQ-030 Saturation and specials:
- scale +250 -> 0x7FFFFFFF, truncated 1.
- scale -250 -> 0x00000001, truncated 1.
- inf=1 -> 0x80000000.
- zero=1 -> 0x00000000.
REQ-031 Ten consecutive starts with distinct vectors -> ten consecutive done pulses, results in order, each matching a reference model.
REQ-032 Assert rst one cycle after two starts -> no done pulses; the next start after release completes in 3 cycles.

Source files
------------

// File: rtl/posit_encode_raw_es3_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | posit_defines_es3 : shared widths, raw-sum layout and posit<32,3> limits    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package posit_defines_es3;

    localparam int POSIT_SERIALIZED_WIDTH_SUM_ES3 = 41;
    // {regime terminator, exponent, fraction, pad}, wide enough for the longest regime
    localparam int ABITS                          = 62;

    localparam logic [31:0] POSIT_ES3_MAXPOS    = 32'h7FFF_FFFF;
    localparam logic [31:0] POSIT_ES3_MINPOS    = 32'h0000_0001;
    localparam logic [31:0] POSIT_ES3_NAR       = 32'h8000_0000;
    localparam int          POSIT_ES3_MAX_SCALE = 240;

    typedef struct packed {
        logic        sgn;
        logic [8:0]  scale;
        logic [28:0] fraction;
        logic        inf;
        logic        zero;
    } value_sum;

endpackage
`default_nettype wire

// File: rtl/posit_encode_raw_es3_shift_right.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | shift_right : logical right shift with selectable fill bit                  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module shift_right #(
    parameter int N = 62,
    parameter int S = 5
) (
    input  logic [N-1:0] data_i,
    input  logic [S-1:0] shamt_i,
    input  logic         fill_i,
    output logic [N-1:0] data_o
);

    // Filling with ones is a zero-fill shift of the complemented word.
    assign data_o = fill_i ? ~((~data_i) >> shamt_i) : (data_i >> shamt_i);

endmodule
`default_nettype wire

// File: rtl/posit_encode_raw_es3.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | posit_encode_raw_es3 : raw {sgn,scale,fraction} -> posit<32,3>, RNE, 4 regs |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module posit_encode_raw_es3
    import posit_defines_es3::*;
(
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic [POSIT_SERIALIZED_WIDTH_SUM_ES3-1:0] in_sum,
    input  logic                                      in_truncated,
    output logic [31:0]                               result,
    output logic                                      done,
    output logic                                      truncated
);

    // ---------------- stage 1: capture and decode the scale -----------------
    value_sum   in_d;
    logic       pos_d;
    logic [4:0] shamt_d;
    logic       sat_hi_d;
    logic       sat_lo_d;

    assign in_d     = in_sum;
    assign pos_d    = ~in_d.scale[8];
    // Regime run length: k+1 ones for k>=0, -k zeros for k<0 (k = scale>>>3).
    assign shamt_d  = pos_d ? (in_d.scale[7:3] + 5'd1) : (5'd0 - in_d.scale[7:3]);
    assign sat_hi_d = int'($signed(in_d.scale)) >  POSIT_ES3_MAX_SCALE;
    assign sat_lo_d = int'($signed(in_d.scale)) < -POSIT_ES3_MAX_SCALE;

    logic        s1_valid_q, s1_sgn_q, s1_inf_q, s1_zero_q, s1_trunc_q;
    logic        s1_pos_q, s1_sat_hi_q, s1_sat_lo_q;
    logic [4:0]  s1_shamt_q;
    logic [2:0]  s1_exp_q;
    logic [28:0] s1_frac_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_sgn_q    <= 1'b0;
            s1_inf_q    <= 1'b0;
            s1_zero_q   <= 1'b0;
            s1_trunc_q  <= 1'b0;
            s1_pos_q    <= 1'b0;
            s1_sat_hi_q <= 1'b0;
            s1_sat_lo_q <= 1'b0;
            s1_shamt_q  <= '0;
            s1_exp_q    <= '0;
            s1_frac_q   <= '0;
        end else begin
            if (start) begin
                s1_valid_q  <= 1'b1;
                s1_sgn_q    <= in_d.sgn;
                s1_inf_q    <= in_d.inf;
                s1_zero_q   <= in_d.zero;
                s1_trunc_q  <= in_truncated;
                s1_pos_q    <= pos_d;
                s1_sat_hi_q <= sat_hi_d;
                s1_sat_lo_q <= sat_lo_d;
                s1_shamt_q  <= shamt_d;
                s1_exp_q    <= in_d.scale[2:0];
                s1_frac_q   <= in_d.fraction;
            end else begin
                s1_valid_q  <= 1'b0;
            end
        end
    end

    // ---------------- stage 2: regime insertion and alignment ---------------
    logic [ABITS-1:0] base_d;
    logic [ABITS-1:0] aligned_d;
    logic [30:0]      mag_d;
    logic             guard_d;
    logic             lost_d;
    logic             sticky_d;

    assign base_d = {~s1_pos_q, s1_exp_q, s1_frac_q, {(ABITS-33){1'b0}}};

    shift_right #(
        .N (ABITS),
        .S (5)
    ) u_align (
        .data_i  (base_d),
        .shamt_i (s1_shamt_q),
        .fill_i  (s1_pos_q),
        .data_o  (aligned_d)
    );

    // The two longest regimes push low fraction bits past the pad.
    assign lost_d   = (s1_shamt_q == 5'd31) ? |s1_frac_q[1:0] :
                      (s1_shamt_q == 5'd30) ? s1_frac_q[0]    : 1'b0;
    assign mag_d    = aligned_d[ABITS-1:ABITS-31];
    assign guard_d  = aligned_d[ABITS-32];
    assign sticky_d = |aligned_d[ABITS-33:0] | lost_d | s1_trunc_q;

    logic        s2_valid_q, s2_sgn_q, s2_inf_q, s2_zero_q;
    logic        s2_sat_hi_q, s2_sat_lo_q, s2_guard_q, s2_sticky_q;
    logic [30:0] s2_mag_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q  <= 1'b0;
            s2_sgn_q    <= 1'b0;
            s2_inf_q    <= 1'b0;
            s2_zero_q   <= 1'b0;
            s2_sat_hi_q <= 1'b0;
            s2_sat_lo_q <= 1'b0;
            s2_guard_q  <= 1'b0;
            s2_sticky_q <= 1'b0;
            s2_mag_q    <= '0;
        end else begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_sgn_q    <= s1_sgn_q;
                s2_inf_q    <= s1_inf_q;
                s2_zero_q   <= s1_zero_q;
                s2_sat_hi_q <= s1_sat_hi_q;
                s2_sat_lo_q <= s1_sat_lo_q;
                s2_guard_q  <= guard_d;
                s2_sticky_q <= sticky_d;
                s2_mag_q    <= mag_d;
            end
        end
    end

    // ---------------- stage 3: round, clamp, sign, specials -----------------
    logic        inc_d;
    logic [31:0] rounded_d;
    logic [31:0] mag32_d;
    logic        inexact_d;
    logic [31:0] res_d;
    logic        trunc_d;

    assign inc_d     = s2_guard_q & (s2_mag_q[0] | s2_sticky_q);
    assign rounded_d = {1'b0, s2_mag_q} + {31'd0, inc_d};

    always_comb begin
        mag32_d   = rounded_d;
        inexact_d = s2_guard_q | s2_sticky_q;
        if (rounded_d[31]) begin
            mag32_d = POSIT_ES3_MAXPOS;
        end else if (rounded_d == 32'd0) begin
            mag32_d = POSIT_ES3_MINPOS;
        end
        if (s2_sat_hi_q) begin
            mag32_d   = POSIT_ES3_MAXPOS;
            inexact_d = 1'b1;
        end else if (s2_sat_lo_q) begin
            mag32_d   = POSIT_ES3_MINPOS;
            inexact_d = 1'b1;
        end
        res_d   = s2_sgn_q ? (32'd0 - mag32_d) : mag32_d;
        trunc_d = inexact_d;
        if (s2_inf_q) begin
            res_d   = POSIT_ES3_NAR;
            trunc_d = 1'b0;
        end else if (s2_zero_q) begin
            res_d   = 32'd0;
            trunc_d = 1'b0;
        end
    end

    logic        s3_valid_q, s3_trunc_q;
    logic [31:0] s3_result_q;
    logic        done_q, truncated_q;
    logic [31:0] result_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_valid_q  <= 1'b0;
            s3_trunc_q  <= 1'b0;
            s3_result_q <= '0;
            done_q      <= 1'b0;
            truncated_q <= 1'b0;
            result_q    <= '0;
        end else begin
            s3_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                s3_result_q <= res_d;
                s3_trunc_q  <= trunc_d;
            end
            // Output register holds its value between done pulses.
            done_q <= s3_valid_q;
            if (s3_valid_q) begin
                result_q    <= s3_result_q;
                truncated_q <= s3_trunc_q;
            end
        end
    end

    assign result    = result_q;
    assign done      = done_q;
    assign truncated = truncated_q;

endmodule
`default_nettype wire

// File: tb/tb_posit_encode_raw_es3.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_posit_encode_raw_es3 : vector table + random stream against a bit model |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_posit_encode_raw_es3;

    logic        clk;
    logic        rst;
    logic        start;
    logic [40:0] in_sum;
    logic        in_truncated;
    logic [31:0] result;
    logic        done;
    logic        truncated;

    posit_encode_raw_es3 dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_sum       (in_sum),
        .in_truncated (in_truncated),
        .result       (result),
        .done         (done),
        .truncated    (truncated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [40:0] sum;
        logic        tin;
        logic [31:0] res;
        logic        trunc;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        trunc;
        int          cyc;
        int          id;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;
    vec_t tbl[18];
    int   cyc;
    int   n_vec;
    int   n_err;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [40:0] mk(input logic sgn, input int scale, input logic [28:0] frac,
                                       input logic inf, input logic zero);
        logic [8:0] sc;
        sc = scale[8:0];
        return {sgn, sc, frac, inf, zero};
    endfunction

    // Independent bit-string model: lay regime, exponent and fraction MSB-first.
    function automatic logic [32:0] model(input logic [40:0] s, input logic tin);
        int          scale, k, e, n;
        logic [63:0] bits;
        logic [31:0] mag;
        logic        g, st, tr;
        scale = int'($signed(s[39:31]));
        if (s[1]) return {1'b0, 32'h8000_0000};
        if (s[0]) return 33'd0;
        if (scale > 240) begin
            mag = 32'h7FFF_FFFF; tr = 1'b1;
        end else if (scale < -240) begin
            mag = 32'h0000_0001; tr = 1'b1;
        end else begin
            e = scale & 7;
            k = (scale - e) / 8;
            bits = '0;
            n = 0;
            if (k >= 0) begin
                for (int i = 0; i <= k; i++) begin bits[63-n] = 1'b1; n++; end
                n++;
            end else begin
                n = n - k;
                bits[63-n] = 1'b1;
                n++;
            end
            for (int i = 2; i >= 0; i--) begin bits[63-n] = ((e >> i) & 1) != 0; n++; end
            for (int i = 28; i >= 0; i--) begin bits[63-n] = s[2+i]; n++; end
            mag = {1'b0, bits[63:33]};
            g   = bits[32];
            st  = (|bits[31:0]) | tin;
            if (g && (mag[0] || st)) mag = mag + 32'd1;
            if (mag > 32'h7FFF_FFFF) mag = 32'h7FFF_FFFF;
            if (mag == 32'd0) mag = 32'd1;
            tr = g | st;
        end
        return {tr, s[40] ? (32'd0 - mag) : mag};
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done: result=%h truncated=%b, no result expected", result, truncated);
            end else begin
                e_mon = sb.pop_front();
                if (result !== e_mon.res || truncated !== e_mon.trunc || cyc != e_mon.cyc) begin
                    n_err++;
                    $display("FAIL vec%0d: got result=%h trunc=%b cycle=%0d, expected result=%h trunc=%b cycle=%0d",
                             e_mon.id, result, truncated, cyc, e_mon.res, e_mon.trunc, e_mon.cyc);
                end
            end
        end
    end

    task automatic send(input logic [40:0] s, input logic t, input logic [31:0] r,
                        input logic tr, input int id);
        exp_t x;
        x.res = r; x.trunc = tr; x.cyc = cyc + 4; x.id = id;
        start = 1'b1; in_sum = s; in_truncated = t;
        sb.push_back(x);
        @(negedge clk);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_reset(input int id);
        n_vec++;
        if (done !== 1'b0 || result !== 32'd0 || truncated !== 1'b0) begin
            n_err++;
            $display("FAIL reset%0d: done=%b result=%h trunc=%b, expected 0/00000000/0",
                     id, done, result, truncated);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [40:0] s;
        logic        t;
        logic [32:0] m;
        cyc = 0; n_vec = 0; n_err = 0;
        rst = 1'b1; start = 1'b0; in_sum = '0; in_truncated = 1'b0;

        tbl[0]  = '{mk(0,    0, 29'h0,        0, 0), 0, 32'h4000_0000, 0};
        tbl[1]  = '{mk(0,    8, 29'h0,        0, 0), 0, 32'h6000_0000, 0};
        tbl[2]  = '{mk(0,    1, 29'h1000_0000, 0, 0), 0, 32'h4600_0000, 0};
        tbl[3]  = '{mk(1,    0, 29'h0,        0, 0), 0, 32'hC000_0000, 0};
        tbl[4]  = '{mk(0,    0, 29'h4,        0, 0), 0, 32'h4000_0000, 1};
        tbl[5]  = '{mk(0,    0, 29'hC,        0, 0), 0, 32'h4000_0002, 1};
        tbl[6]  = '{mk(0,    0, 29'h0,        0, 0), 1, 32'h4000_0000, 1};
        tbl[7]  = '{mk(0,  250, 29'h0,        0, 0), 0, 32'h7FFF_FFFF, 1};
        tbl[8]  = '{mk(0, -250, 29'h0,        0, 0), 0, 32'h0000_0001, 1};
        tbl[9]  = '{mk(0,    5, 29'h0ABC,     1, 1), 0, 32'h8000_0000, 0};
        tbl[10] = '{mk(0,    3, 29'h0123,     0, 1), 1, 32'h0000_0000, 0};
        tbl[11] = '{mk(0,   -1, 29'h0,        0, 0), 0, 32'h3C00_0000, 0};
        tbl[12] = '{mk(0,  240, 29'h0,        0, 0), 0, 32'h7FFF_FFFF, 0};
        tbl[13] = '{mk(0, -240, 29'h0,        0, 0), 0, 32'h0000_0001, 0};
        tbl[14] = '{mk(0,  239, 29'h1FFF_FFFF, 0, 0), 0, 32'h7FFF_FFFF, 1};
        tbl[15] = '{mk(1,    8, 29'h0,        0, 0), 0, 32'hA000_0000, 0};
        tbl[16] = '{mk(1, -250, 29'h0,        0, 0), 0, 32'hFFFF_FFFF, 1};
        tbl[17] = '{mk(0,    0, 29'h14,       0, 0), 0, 32'h4000_0002, 1};

        repeat (3) @(negedge clk);
        chk_reset(0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 18; i++) send(tbl[i].sum, tbl[i].tin, tbl[i].res, tbl[i].trunc, i);
        start = 1'b0;
        drain();

        n_vec++;
        if (done !== 1'b0 || result !== tbl[17].res || truncated !== tbl[17].trunc) begin
            n_err++;
            $display("FAIL hold: done=%b result=%h trunc=%b, expected 0/%h/%b",
                     done, result, truncated, tbl[17].res, tbl[17].trunc);
        end

        for (int i = 0; i < 10; i++) begin
            s = mk(1'($urandom_range(0, 1)), int'($urandom_range(0, 500)) - 250, 29'($urandom),
                   ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
            t = ($urandom_range(0, 3) == 0);
            m = model(s, t);
            send(s, t, m[31:0], m[32], 100 + i);
        end
        start = 1'b0;
        drain();

        m = model(tbl[2].sum, 1'b0);
        send(tbl[2].sum, 1'b0, m[31:0], m[32], 200);
        m = model(tbl[15].sum, 1'b0);
        send(tbl[15].sum, 1'b0, m[31:0], m[32], 201);
        start = 1'b0;
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        chk_reset(1);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        send(tbl[1].sum, 1'b0, 32'h6000_0000, 1'b0, 300);
        start = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
